// File: rtl/proc_pkg.sv
// Shared encodings for the multi-cycle processor: opcodes, extender/PC/writeback
// selects, ALU ops and the control FSM state type.
package proc_pkg;

  localparam logic [5:0] OP_RALU  = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h01;
  localparam logic [5:0] OP_LOAD  = 6'h02;
  localparam logic [5:0] OP_STORE = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_JMP   = 6'h06;
  localparam logic [5:0] OP_JAL   = 6'h07;
  localparam logic [5:0] OP_IN    = 6'h08;
  localparam logic [5:0] OP_OUT   = 6'h09;
  localparam logic [5:0] OP_HALT  = 6'h3F;

  // extender select, also used by the sign-extender itself
  localparam logic [1:0] EXT_J26 = 2'b00;
  localparam logic [1:0] EXT_I14 = 2'b01;
  localparam logic [1:0] EXT_B17 = 2'b10;

  localparam logic [1:0] PC_INC    = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  localparam logic [1:0] WB_ALU  = 2'b00;
  localparam logic [1:0] WB_MEM  = 2'b01;
  localparam logic [1:0] WB_LINK = 2'b10;
  localparam logic [1:0] WB_IN   = 2'b11;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_FUNCT = 4'd2;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_IO, S_HALTED
  } state_t;

  function automatic logic [1:0] ext_for(input logic [5:0] op);
    case (op)
      OP_ADDI, OP_LOAD, OP_STORE: return EXT_I14;
      OP_BEQ, OP_BNE:             return EXT_B17;
      default:                    return EXT_J26;
    endcase
  endfunction

  function automatic logic op_legal(input logic [5:0] op);
    case (op)
      OP_RALU, OP_ADDI, OP_LOAD, OP_STORE, OP_BEQ, OP_BNE,
      OP_JMP, OP_JAL, OP_IN, OP_OUT, OP_HALT: return 1'b1;
      default:                                return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/multiciclo_control_if.sv
// Control <-> datapath/IO bundle. master = control unit, slave = datapath side.
interface multiciclo_control_if;
  logic [31:0] instr;
  logic        alu_zero;
  logic        mem_ready;
  logic        in_valid;
  logic        out_ready;
  logic        resume;

  logic        imem_req;
  logic        ir_write;
  logic        pc_write;
  logic [1:0]  pc_src;
  logic [1:0]  ext_select;
  logic        alu_src;
  logic [3:0]  alu_op;
  logic        dmem_read;
  logic        dmem_write;
  logic        reg_write;
  logic [1:0]  wb_sel;
  logic        in_ack;
  logic        out_valid;
  logic        halted;
  logic        bus_error;
  logic        illegal;

  modport master (
    input  instr, alu_zero, mem_ready, in_valid, out_ready, resume,
    output imem_req, ir_write, pc_write, pc_src, ext_select, alu_src, alu_op,
           dmem_read, dmem_write, reg_write, wb_sel, in_ack, out_valid,
           halted, bus_error, illegal
  );

  modport slave (
    output instr, alu_zero, mem_ready, in_valid, out_ready, resume,
    input  imem_req, ir_write, pc_write, pc_src, ext_select, alu_src, alu_op,
           dmem_read, dmem_write, reg_write, wb_sel, in_ack, out_valid,
           halted, bus_error, illegal
  );
endinterface

// File: rtl/mem_wait_timer.sv
// Memory wait counter: counts stalled request cycles, flags the last allowed one.
module mem_wait_timer #(
  parameter int WAIT_LIMIT = 16,
  parameter int CNT_W      = 5
) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic timeout
);
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)   cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en)  cnt <= cnt + 1'b1;
  end

  // fires on the stalled cycle that would bring the count to WAIT_LIMIT
  assign timeout = en && !clr && (cnt == CNT_W'(WAIT_LIMIT - 1));
endmodule

// File: rtl/multiciclo_control.sv
// Multi-cycle control FSM: fetch/decode/exec/mem/wb/io sequencing, one instruction at a time.
module multiciclo_control
  import proc_pkg::*;
#(
  parameter int WAIT_LIMIT = 16,
  parameter int CNT_W      = 5
) (
  input  logic                  clock,
  input  logic                  reset,
  multiciclo_control_if.master  bus
);
  state_t     state, state_nx;
  logic       bus_err_q, ill_q;
  logic       set_bus, set_ill, clr_flags;
  logic       waiting, tmo;
  logic [5:0] op;

  assign op      = bus.instr[31:26];
  assign waiting = !reset && (state == S_FETCH || state == S_MEM);

  mem_wait_timer #(.WAIT_LIMIT(WAIT_LIMIT), .CNT_W(CNT_W)) u_timer (
    .clock   (clock),
    .reset   (reset),
    .clr     (!waiting || bus.mem_ready),
    .en      (waiting),
    .timeout (tmo)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= S_FETCH;
      bus_err_q <= 1'b0;
      ill_q     <= 1'b0;
    end else begin
      state <= state_nx;
      if (clr_flags) begin
        bus_err_q <= 1'b0;
        ill_q     <= 1'b0;
      end
      if (set_bus) bus_err_q <= 1'b1;
      if (set_ill) ill_q     <= 1'b1;
    end
  end

  assign bus.bus_error = bus_err_q;
  assign bus.illegal   = ill_q;

  always_comb begin
    state_nx       = state;
    set_bus        = 1'b0;
    set_ill        = 1'b0;
    clr_flags      = 1'b0;
    bus.imem_req   = 1'b0;
    bus.ir_write   = 1'b0;
    bus.pc_write   = 1'b0;
    bus.pc_src     = PC_INC;
    bus.ext_select = EXT_J26;
    bus.alu_src    = 1'b0;
    bus.alu_op     = ALU_ADD;
    bus.dmem_read  = 1'b0;
    bus.dmem_write = 1'b0;
    bus.reg_write  = 1'b0;
    bus.wb_sel     = WB_ALU;
    bus.in_ack     = 1'b0;
    bus.out_valid  = 1'b0;
    bus.halted     = 1'b0;
    // outputs stay quiet while reset is held, even though state reads FETCH
    if (!reset) begin
      unique case (state)
        S_FETCH: begin
          bus.imem_req = 1'b1;
          if (bus.mem_ready) begin
            bus.ir_write = 1'b1;
            bus.pc_write = 1'b1;
            state_nx     = S_DECODE;
          end else if (tmo) begin
            set_bus  = 1'b1;
            state_nx = S_HALTED;
          end
        end
        S_DECODE: begin
          bus.ext_select = ext_for(op);
          if (!op_legal(op)) begin
            set_ill  = 1'b1;
            state_nx = S_HALTED;
          end else if (op == OP_HALT) state_nx = S_HALTED;
          else                        state_nx = S_EXEC;
        end
        S_EXEC: begin
          bus.ext_select = ext_for(op);
          state_nx       = S_FETCH;
          case (op)
            OP_RALU: begin bus.alu_op = ALU_FUNCT; state_nx = S_WB; end
            OP_ADDI: begin bus.alu_src = 1'b1; state_nx = S_WB; end
            OP_LOAD, OP_STORE: begin bus.alu_src = 1'b1; state_nx = S_MEM; end
            OP_BEQ, OP_BNE: begin
              bus.alu_op   = ALU_SUB;
              bus.pc_src   = PC_BRANCH;
              bus.pc_write = (op == OP_BEQ) ? bus.alu_zero : !bus.alu_zero;
            end
            OP_JMP, OP_JAL: begin
              bus.pc_write = 1'b1;
              bus.pc_src   = PC_JUMP;
              if (op == OP_JAL) state_nx = S_WB;
            end
            OP_IN, OP_OUT: state_nx = S_IO;
            default: state_nx = S_FETCH;
          endcase
        end
        S_MEM: begin
          bus.ext_select = ext_for(op);
          bus.dmem_read  = (op == OP_LOAD);
          bus.dmem_write = (op == OP_STORE);
          if (bus.mem_ready) state_nx = (op == OP_LOAD) ? S_WB : S_FETCH;
          else if (tmo) begin
            set_bus  = 1'b1;
            state_nx = S_HALTED;
          end
        end
        S_WB: begin
          bus.ext_select = ext_for(op);
          bus.reg_write  = 1'b1;
          bus.wb_sel     = (op == OP_LOAD) ? WB_MEM : (op == OP_JAL) ? WB_LINK : WB_ALU;
          state_nx       = S_FETCH;
        end
        S_IO: begin
          if (op == OP_IN) begin
            bus.wb_sel = WB_IN;
            if (bus.in_valid) begin
              bus.in_ack    = 1'b1;
              bus.reg_write = 1'b1;
              state_nx      = S_FETCH;
            end
          end else begin
            bus.out_valid = 1'b1;
            if (bus.out_ready) state_nx = S_FETCH;
          end
        end
        S_HALTED: begin
          bus.halted = 1'b1;
          if (bus.resume) begin
            clr_flags = 1'b1;
            state_nx  = S_FETCH;
          end
        end
        default: state_nx = S_FETCH;
      endcase
    end
  end
endmodule

// File: tb/tb_multiciclo_control.sv
// Bench: per-instruction expected cycle traces built from the ISA timing rules,
// replayed against the control unit with random noise on don't-care inputs.
module tb_multiciclo_control;
  localparam int LIM = 16;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  multiciclo_control_if bus();
  multiciclo_control #(.WAIT_LIMIT(LIM), .CNT_W(5)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic       imem_req, ir_write, pc_write;
    logic [1:0] pc_src, ext_select;
    logic       alu_src;
    logic [3:0] alu_op;
    logic       dmem_read, dmem_write, reg_write;
    logic [1:0] wb_sel;
    logic       in_ack, out_valid, halted, bus_error, illegal;
  } ov_t;

  typedef struct {
    logic [31:0] instr;
    logic        az, mr, iv, ordy, rs;
    ov_t         exp;
    logic [47:0] ph;
  } step_t;

  step_t q[$];
  int nvec = 0;
  int nerr = 0;

  function automatic ov_t sample();
    ov_t o;
    o = '{bus.imem_req, bus.ir_write, bus.pc_write, bus.pc_src, bus.ext_select,
          bus.alu_src, bus.alu_op, bus.dmem_read, bus.dmem_write, bus.reg_write,
          bus.wb_sel, bus.in_ack, bus.out_valid, bus.halted, bus.bus_error, bus.illegal};
    return o;
  endfunction

  task automatic chk(input ov_t exp, input logic [47:0] ph);
    ov_t got;
    got = sample();
    nvec++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s instr=%h got=%h want=%h", ph, bus.instr, got, exp);
    end
  endtask

  // every input random by default; callers pin the ones that matter
  function automatic step_t ns(input logic [31:0] ins, input logic [47:0] ph);
    step_t s;
    s.instr = ins;
    s.az = 1'($urandom_range(0, 1));
    s.mr = 1'($urandom_range(0, 1));
    s.iv = 1'($urandom_range(0, 1));
    s.ordy = 1'($urandom_range(0, 1));
    s.rs = 1'($urandom_range(0, 1));
    s.exp = '0;
    s.ph = ph;
    return s;
  endfunction

  task automatic gen_halt(input logic [31:0] ins, input logic be, input logic il);
    step_t s;
    int h;
    h = $urandom_range(0, 2);
    for (int i = 0; i <= h; i++) begin
      s = ns(ins, "HALTED");
      s.rs = (i == h);
      s.exp.halted = 1'b1;
      s.exp.bus_error = be;
      s.exp.illegal = il;
      q.push_back(s);
    end
  endtask

  // df/dm >= LIM means memory never answers
  task automatic gen_instr(input logic [31:0] ins, input int df, input int dm,
                           input int di, input logic az);
    step_t s;
    logic [5:0] op;
    logic [1:0] ex;
    int n;
    op = ins[31:26];
    ex = (op == 6'd1 || op == 6'd2 || op == 6'd3) ? 2'b01 :
         (op == 6'd4 || op == 6'd5) ? 2'b10 : 2'b00;
    n = (df >= LIM) ? LIM : df;
    for (int i = 0; i < n; i++) begin
      s = ns(ins, "FETCH "); s.mr = 1'b0; s.exp.imem_req = 1'b1; q.push_back(s);
    end
    if (df >= LIM) begin gen_halt(ins, 1'b1, 1'b0); return; end
    s = ns(ins, "FETCH "); s.mr = 1'b1;
    s.exp.imem_req = 1'b1; s.exp.ir_write = 1'b1; s.exp.pc_write = 1'b1;
    q.push_back(s);
    s = ns(ins, "DECODE"); s.exp.ext_select = ex; q.push_back(s);
    if (!(op <= 6'd9 || op == 6'h3F)) begin gen_halt(ins, 1'b0, 1'b1); return; end
    if (op == 6'h3F) begin gen_halt(ins, 1'b0, 1'b0); return; end
    s = ns(ins, "EXEC  "); s.az = az; s.exp.ext_select = ex;
    case (op)
      6'd0: s.exp.alu_op = 4'd2;
      6'd1, 6'd2, 6'd3: s.exp.alu_src = 1'b1;
      6'd4, 6'd5: begin
        s.exp.alu_op = 4'd1; s.exp.pc_src = 2'b01;
        s.exp.pc_write = (op == 6'd4) ? az : !az;
      end
      6'd6, 6'd7: begin s.exp.pc_write = 1'b1; s.exp.pc_src = 2'b10; end
      default: ;
    endcase
    q.push_back(s);
    if (op == 6'd4 || op == 6'd5 || op == 6'd6) return;
    if (op == 6'd2 || op == 6'd3) begin
      n = (dm >= LIM) ? LIM : dm;
      for (int i = 0; i <= n; i++) begin
        if (i == n && dm >= LIM) begin gen_halt(ins, 1'b1, 1'b0); return; end
        s = ns(ins, "MEM   "); s.mr = (i == n);
        s.exp.ext_select = ex;
        s.exp.dmem_read = (op == 6'd2); s.exp.dmem_write = (op == 6'd3);
        q.push_back(s);
      end
      if (op == 6'd3) return;
    end
    if (op == 6'd8 || op == 6'd9) begin
      for (int i = 0; i <= di; i++) begin
        s = ns(ins, "IO    ");
        if (op == 6'd8) begin
          s.iv = (i == di); s.exp.wb_sel = 2'b11;
          s.exp.in_ack = (i == di); s.exp.reg_write = (i == di);
        end else begin
          s.ordy = (i == di); s.exp.out_valid = 1'b1;
        end
        q.push_back(s);
      end
      return;
    end
    s = ns(ins, "WB    "); s.exp.ext_select = ex; s.exp.reg_write = 1'b1;
    s.exp.wb_sel = (op == 6'd2) ? 2'b01 : (op == 6'd7) ? 2'b10 : 2'b00;
    q.push_back(s);
  endtask

  initial begin
    step_t s;
    ov_t e;
    logic [5:0] op;
    int k;
    bus.instr = '0; bus.alu_zero = 0; bus.mem_ready = 0;
    bus.in_valid = 0; bus.out_ready = 0; bus.resume = 0;
    @(negedge clock);
    chk('0, "RESET ");
    @(posedge clock); #1 reset = 1'b0;

    gen_instr(32'h0400_0005, 0, 0, 0, 1'b0);     // ADDI
    gen_instr(32'h1000_0010, 2, 0, 0, 1'b1);     // BEQ taken
    gen_instr(32'h1000_0010, 0, 0, 0, 1'b0);     // BEQ not taken
    gen_instr(32'h1400_0020, 1, 0, 0, 1'b0);     // BNE taken
    gen_instr(32'h0800_0004, 0, 3, 0, 1'b0);     // LOAD, 3 stall cycles
    gen_instr(32'h0C00_0004, 0, 0, 0, 1'b0);     // STORE
    gen_instr(32'h0400_0001, LIM, 0, 0, 1'b0);   // fetch timeout
    gen_instr(32'hA800_0000, 0, 0, 0, 1'b0);     // opcode 0x2A
    gen_instr(32'h2000_0000, 0, 0, 5, 1'b0);     // IN after 5 cycles
    gen_instr(32'h1C00_0100, 0, 0, 0, 1'b0);     // JAL
    gen_instr(32'h2400_0000, 0, 0, 2, 1'b0);     // OUT
    gen_instr(32'hFC00_0000, 0, 0, 0, 1'b0);     // HALT
    gen_instr(32'h0800_0008, 0, LIM, 0, 1'b0);   // data timeout
    gen_instr(32'h0800_0008, 0, LIM - 1, 0, 1'b0); // ready on last allowed cycle
    gen_instr(32'h1800_0000, 0, 0, 0, 1'b0);     // JMP
    gen_instr(32'h0000_0003, 0, 0, 0, 1'b0);     // R-ALU
    for (int n = 0; n < 150; n++) begin
      k = $urandom_range(0, 13);
      op = (k <= 9) ? 6'(k) : (k == 10) ? 6'h3F : (k == 11) ? 6'h2A
                                        : 6'($urandom_range(10, 62));
      gen_instr({op, 26'($urandom)},
                ($urandom_range(0, 11) == 0) ? LIM : $urandom_range(0, 4),
                ($urandom_range(0, 11) == 0) ? LIM : $urandom_range(0, 4),
                $urandom_range(0, 6), 1'($urandom_range(0, 1)));
    end

    while (q.size() > 0) begin
      s = q.pop_front();
      bus.instr = s.instr; bus.alu_zero = s.az; bus.mem_ready = s.mr;
      bus.in_valid = s.iv; bus.out_ready = s.ordy; bus.resume = s.rs;
      @(negedge clock);
      chk(s.exp, s.ph);
      @(posedge clock); #1;
    end

    // LOAD into MEM, then asynchronous reset mid-cycle
    bus.instr = 32'h0800_0004; bus.resume = 0; bus.in_valid = 0; bus.out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      bus.mem_ready = (i == 0);
      @(posedge clock); #1;
    end
    bus.mem_ready = 0;
    @(negedge clock);
    e = '0; e.dmem_read = 1'b1; e.ext_select = 2'b01;
    chk(e, "MEM   ");
    #1 reset = 1'b1;
    #1 chk('0, "RSTMEM");
    #1 reset = 1'b0;
    e = '0; e.imem_req = 1'b1;
    #1 chk(e, "RSTFET");
    @(posedge clock); #1;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
